// File: rtl/fm_tune_sequencer_if.sv
// -----------------------------------------------------------------------------
// fm_tune_sequencer_if
// Configuration request bus between the SPI configuration core and the FM
// tune sequencer.
//
//   cfg_valid    one-cycle request strobe (clk domain)
//   cfg_acc_inc  requested carrier phase increment   [N-1:0]
//   cfg_df_inc   requested deviation increment       [L-1:0]
//   cfg_dac_ena  requested DAC bit enables           [D-1:0]
//   busy         sequencer status: retune running or queued
//
// master : configuration core (drives the request, observes busy)
// slave  : tune sequencer     (accepts the request, drives busy)
// -----------------------------------------------------------------------------
interface fm_tune_sequencer_if #(
   parameter int N = 18,
   parameter int L = 12,
   parameter int D = 4
);

   logic         cfg_valid;
   logic [N-1:0] cfg_acc_inc;
   logic [L-1:0] cfg_df_inc;
   logic [D-1:0] cfg_dac_ena;
   logic         busy;

   modport master (
      output cfg_valid, cfg_acc_inc, cfg_df_inc, cfg_dac_ena,
      input  busy
   );

   modport slave (
      input  cfg_valid, cfg_acc_inc, cfg_df_inc, cfg_dac_ena,
      output busy
   );

endinterface : fm_tune_sequencer_if

// File: rtl/fm_tune_sequencer.sv
// -----------------------------------------------------------------------------
// fm_tune_sequencer
// Owns the live FM modulator settings and applies new ones click-free:
// mute audio, glide the carrier increment in bounded steps, apply deviation
// and DAC enables together, let things settle, then unmute. Requests that
// arrive mid-sequence are queued; the most recent one wins.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   cfg_if     slave side of the configuration request bus (request + busy)
//   acc_inc_o  live carrier increment to the modulator     [N-1:0]
//   df_inc_o   live deviation increment                    [L-1:0]
//   dac_ena_o  live DAC bit enables                        [D-1:0]
//   mute_o     1 = modulator audio forced to zero
// All outputs are registered.
// -----------------------------------------------------------------------------
module fm_tune_sequencer #(
   parameter int N           = 18,
   parameter int L           = 12,
   parameter int D           = 4,
   parameter int ACC_INC_RST = 52429,
   parameter int DF_INC_RST  = 393,
   parameter int GLIDE_STEP  = 256,
   parameter int GLIDE_DIV   = 16,
   parameter int MUTE_CYC    = 64,
   parameter int SETTLE_CYC  = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   fm_tune_sequencer_if.slave   cfg_if,
   output logic [N-1:0]         acc_inc_o,
   output logic [L-1:0]         df_inc_o,
   output logic [D-1:0]         dac_ena_o,
   output logic                 mute_o
);

   // One counter serves the mute hold, the glide divider and the settle hold.
   localparam int CNT_MAX = (MUTE_CYC > SETTLE_CYC)
                            ? ((MUTE_CYC > GLIDE_DIV) ? MUTE_CYC : GLIDE_DIV)
                            : ((SETTLE_CYC > GLIDE_DIV) ? SETTLE_CYC : GLIDE_DIV);
   localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {IDLE, MUTE, GLIDE, SETTLE} state_t;

   typedef struct packed {
      logic [N-1:0] acc;
      logic [L-1:0] df;
      logic [D-1:0] ena;
   } cfg_t;

   localparam cfg_t CFG_RST = '{acc: N'(ACC_INC_RST), df: L'(DF_INC_RST), ena: '1};

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   cfg_t          tgt_q, tgt_d;
   cfg_t          pend_cfg_q, pend_cfg_d;
   logic          pend_q, pend_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [L-1:0]  df_q, df_d;
   logic [D-1:0]  ena_q, ena_d;
   logic          mute_q, mute_d;
   logic          busy_q, busy_d;

   cfg_t          cfg_in;
   logic          mute_last, div_last, settle_last, at_target;
   logic [N:0]    acc_x, tgt_x, diff_x, step_x, up_x, dn_x;
   logic [N-1:0]  acc_step;

   assign cfg_in      = {cfg_if.cfg_acc_inc, cfg_if.cfg_df_inc, cfg_if.cfg_dac_ena};
   assign mute_last   = (cnt_q == CW'(MUTE_CYC - 1));
   assign div_last    = (cnt_q == CW'(GLIDE_DIV - 1));
   assign settle_last = (cnt_q == CW'(SETTLE_CYC - 1));
   assign at_target   = (acc_q == tgt_q.acc);

   // Glide step on N+1 bits: land exactly on the target when it is within one
   // step, otherwise move a full step toward it. Neither branch can wrap.
   always_comb begin
      acc_x  = {1'b0, acc_q};
      tgt_x  = {1'b0, tgt_q.acc};
      step_x = (N+1)'(GLIDE_STEP);
      diff_x = (tgt_x > acc_x) ? (tgt_x - acc_x) : (acc_x - tgt_x);
      up_x   = acc_x + step_x;
      dn_x   = acc_x - step_x;
      if (diff_x <= step_x) begin
         acc_step = tgt_q.acc;
      end else if (tgt_x > acc_x) begin
         acc_step = up_x[N-1:0];
      end else begin
         acc_step = dn_x[N-1:0];
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tgt_q      <= CFG_RST;
         pend_cfg_q <= '0;
         pend_q     <= 1'b0;
         acc_q      <= N'(ACC_INC_RST);
         df_q       <= L'(DF_INC_RST);
         ena_q      <= '1;
         mute_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tgt_q      <= tgt_d;
         pend_cfg_q <= pend_cfg_d;
         pend_q     <= pend_d;
         acc_q      <= acc_d;
         df_q       <= df_d;
         ena_q      <= ena_d;
         mute_q     <= mute_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:   if (cfg_if.cfg_valid) state_d = MUTE;
         MUTE:   if (mute_last)        state_d = GLIDE;
         GLIDE:  if (at_target)        state_d = SETTLE;
         SETTLE: if (settle_last)      state_d = (cfg_if.cfg_valid || pend_q) ? MUTE : IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      cnt_d      = cnt_q;
      tgt_d      = tgt_q;
      pend_cfg_d = pend_cfg_q;
      pend_d     = pend_q;
      acc_d      = acc_q;
      df_d       = df_q;
      ena_d      = ena_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cfg_if.cfg_valid) tgt_d = cfg_in;
         end
         MUTE: begin
            cnt_d = mute_last ? '0 : cnt_q + 1'b1;
         end
         GLIDE: begin
            if (at_target) begin
               // Deviation and DAC enables change together, once the carrier has arrived.
               cnt_d = '0;
               df_d  = tgt_q.df;
               ena_d = tgt_q.ena;
            end else if (div_last) begin
               cnt_d = '0;
               acc_d = acc_step;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SETTLE: begin
            if (settle_last) begin
               // A strobe on the exit cycle is newer than anything queued.
               cnt_d  = '0;
               pend_d = 1'b0;
               if (cfg_if.cfg_valid) begin
                  tgt_d = cfg_in;
               end else if (pend_q) begin
                  tgt_d = pend_cfg_q;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: cnt_d = '0;
      endcase

      // Mid-sequence requests collapse into one queued entry.
      if (cfg_if.cfg_valid && (state_q != IDLE) && !((state_q == SETTLE) && settle_last)) begin
         pend_cfg_d = cfg_in;
         pend_d     = 1'b1;
      end

      // Decoded from the next state so mute/busy stay high across back-to-back sequences.
      mute_d = (state_d != IDLE);
      busy_d = (state_d != IDLE);
   end

   assign acc_inc_o   = acc_q;
   assign df_inc_o    = df_q;
   assign dac_ena_o   = ena_q;
   assign mute_o      = mute_q;
   assign cfg_if.busy = busy_q;

endmodule : fm_tune_sequencer

// File: tb/tb_fm_tune_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fm_tune_sequencer
// Directed bench for fm_tune_sequencer with default parameters. Edge numbers
// in comments count posedges after the request strobe was sampled (E0).
// -----------------------------------------------------------------------------
module tb_fm_tune_sequencer;

   localparam int N = 18;
   localparam int L = 12;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] acc_inc;
   logic [L-1:0] df_inc;
   logic [D-1:0] dac_ena;
   logic         mute;

   int n_vec     = 0;
   int n_err     = 0;
   int edge_n    = 0;
   int mute_low  = 0;
   int busy_low  = 0;

   fm_tune_sequencer_if #(.N(N), .L(L), .D(D)) cfg_if ();

   fm_tune_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_if    (cfg_if),
      .acc_inc_o (acc_inc),
      .df_inc_o  (df_inc),
      .dac_ena_o (dac_ena),
      .mute_o    (mute)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one edge and sample 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
      if (!mute)        mute_low++;
      if (!cfg_if.busy) busy_low++;
   endtask

   task automatic advance_to(input int k);
      while (edge_n < k) tick();
   endtask

   // Request sampled on the next edge; that edge becomes E0.
   task automatic strobe(input int acc, input int df, input int ena);
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_acc_inc = N'(acc);
      cfg_if.cfg_df_inc  = L'(df);
      cfg_if.cfg_dac_ena = D'(ena);
      tick();
      cfg_if.cfg_valid = 1'b0;
      edge_n   = 0;
      mute_low = 0;
      busy_low = 0;
   endtask

   // Request sampled on edge edge_n+1 without resetting the edge count.
   task automatic pulse(input int acc, input int df, input int ena);
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_acc_inc = N'(acc);
      cfg_if.cfg_df_inc  = L'(df);
      cfg_if.cfg_dac_ena = D'(ena);
      tick();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_acc"},  32'(acc_inc),     32'd52429);
      check({tag, "_df"},   32'(df_inc),      32'd393);
      check({tag, "_ena"},  32'(dac_ena),     32'hF);
      check({tag, "_mute"}, 32'(mute),        32'd0);
      check({tag, "_busy"}, 32'(cfg_if.busy), 32'd0);
   endtask

   initial begin
      int changes;
      cfg_if.cfg_valid   = 1'b0;
      cfg_if.cfg_acc_inc = '0;
      cfg_if.cfg_df_inc  = '0;
      cfg_if.cfg_dac_ena = '0;

      // 1. Reset and idle hold.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_reset_vals("rst");
      changes = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (acc_inc !== 18'd52429 || df_inc !== 12'd393 || dac_ena !== 4'hF ||
             mute !== 1'b0 || cfg_if.busy !== 1'b0) changes++;
      end
      check("idle_hold_changes", 32'(changes), 32'd0);

      // 2. Up-retune 52429 -> 53429: steps at E80/96/112/128, apply at E129, unmute at E193.
      strobe(53429, 500, 3);
      check("up_e0_mute", 32'(mute), 32'd1);
      check("up_e0_busy", 32'(cfg_if.busy), 32'd1);
      check("up_e0_acc",  32'(acc_inc), 32'd52429);
      advance_to(79);
      check("up_e79_acc", 32'(acc_inc), 32'd52429);
      advance_to(80);
      check("up_e80_acc", 32'(acc_inc), 32'd52685);
      advance_to(95);
      check("up_e95_acc", 32'(acc_inc), 32'd52685);
      advance_to(96);
      check("up_e96_acc", 32'(acc_inc), 32'd52941);
      advance_to(112);
      check("up_e112_acc", 32'(acc_inc), 32'd53197);
      advance_to(128);
      check("up_e128_acc", 32'(acc_inc), 32'd53429);
      check("up_e128_df",  32'(df_inc),  32'd393);
      check("up_e128_ena", 32'(dac_ena), 32'hF);
      advance_to(129);
      check("up_e129_df",  32'(df_inc),  32'd500);
      check("up_e129_ena", 32'(dac_ena), 32'd3);
      advance_to(192);
      check("up_e192_mute", 32'(mute), 32'd1);
      check("up_mute_gaps", 32'(mute_low), 32'd0);
      advance_to(193);
      check("up_e193_mute", 32'(mute), 32'd0);
      check("up_e193_busy", 32'(cfg_if.busy), 32'd0);

      // 3. Down-retune 53429 -> 53300: one -129 step at E80, settle E81, idle E145.
      strobe(53300, 500, 3);
      advance_to(79);
      check("dn_e79_acc", 32'(acc_inc), 32'd53429);
      advance_to(80);
      check("dn_e80_acc", 32'(acc_inc), 32'd53300);
      advance_to(96);
      check("dn_e96_acc", 32'(acc_inc), 32'd53300);
      advance_to(144);
      check("dn_e144_busy", 32'(cfg_if.busy), 32'd1);
      advance_to(145);
      check("dn_e145_busy", 32'(cfg_if.busy), 32'd0);

      // 4. Same-value retune: GLIDE at E64 for one cycle, df applied at E65.
      strobe(53300, 600, 3);
      advance_to(64);
      check("eq_e64_df", 32'(df_inc), 32'd500);
      advance_to(65);
      check("eq_e65_df",  32'(df_inc),  32'd600);
      check("eq_e65_acc", 32'(acc_inc), 32'd53300);
      advance_to(129);
      check("eq_e129_busy", 32'(cfg_if.busy), 32'd0);

      // 5. Back-to-back: 53300 -> 54324 (settle E129, exit E193), with 60000/61000/62000
      //    queued during GLIDE. Then 54324 -> 62000: 30 steps from E273 to E737.
      strobe(54324, 400, 5);
      advance_to(70);
      pulse(60000, 700, 1);
      pulse(61000, 701, 2);
      pulse(62000, 702, 4);
      advance_to(80);
      check("b2b_e80_acc", 32'(acc_inc), 32'd53556);
      advance_to(129);
      check("b2b_e129_acc", 32'(acc_inc), 32'd54324);
      check("b2b_e129_df",  32'(df_inc),  32'd400);
      check("b2b_e129_ena", 32'(dac_ena), 32'd5);
      advance_to(193);
      check("b2b_e193_mute", 32'(mute), 32'd1);
      check("b2b_e193_busy", 32'(cfg_if.busy), 32'd1);
      advance_to(257);
      check("b2b_e257_acc", 32'(acc_inc), 32'd54324);
      advance_to(273);
      check("b2b_e273_acc", 32'(acc_inc), 32'd54580);
      advance_to(736);
      check("b2b_e736_acc", 32'(acc_inc), 32'd61748);
      check("b2b_e736_df",  32'(df_inc),  32'd400);
      advance_to(737);
      check("b2b_e737_acc", 32'(acc_inc), 32'd62000);
      advance_to(738);
      check("b2b_e738_df",  32'(df_inc),  32'd702);
      check("b2b_e738_ena", 32'(dac_ena), 32'd4);
      advance_to(801);
      check("b2b_mute_gaps", 32'(mute_low), 32'd0);
      check("b2b_busy_gaps", 32'(busy_low), 32'd0);
      advance_to(802);
      check("b2b_e802_busy", 32'(cfg_if.busy), 32'd0);
      check("b2b_e802_mute", 32'(mute), 32'd0);

      // 5b. Strobe on the SETTLE exit edge (E129) beats the older queued 50000.
      strobe(62000, 10, 1);
      advance_to(10);
      pulse(50000, 20, 8);
      advance_to(128);
      pulse(62000, 30, 2);
      check("col_e129_busy", 32'(cfg_if.busy), 32'd1);
      check("col_e129_df",   32'(df_inc), 32'd10);
      advance_to(194);
      check("col_e194_df",  32'(df_inc),  32'd30);
      check("col_e194_ena", 32'(dac_ena), 32'd2);
      check("col_e194_acc", 32'(acc_inc), 32'd62000);
      advance_to(257);
      check("col_mute_gaps", 32'(mute_low), 32'd0);
      advance_to(258);
      check("col_e258_busy", 32'(cfg_if.busy), 32'd0);
      check("col_e258_acc",  32'(acc_inc), 32'd62000);

      // 6. Reset mid-glide at acc=52941 with a queued request, which must be lost.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("rst2");
      strobe(53429, 500, 3);
      advance_to(90);
      pulse(60000, 700, 1);
      advance_to(96);
      check("mid_e96_acc", 32'(acc_inc), 32'd52941);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("midrst");
      repeat (200) tick();
      check_reset_vals("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fm_tune_sequencer

// File: doc/fm_tune_sequencer.md
Name: fm_tune_sequencer

Overview:
- Sits between the SPI configuration core and the FM modulator, in the clk domain.
- Owns the live modulator settings: acc_inc, df_inc and dac_ena.
- On a configuration request it runs a fixed sequence: mute the audio, glide the carrier increment to its new value in bounded steps, apply deviation and DAC enables, settle, then unmute.
- This prevents spectral splatter and clicks on retune. Requests that arrive while a sequence is running are queued; the latest request wins.

Parameters:
- N, 18, phase-accumulator increment width
- L, 12, deviation increment width
- D, 4, DAC bit count
- ACC_INC_RST, 52429, reset carrier increment (10 MHz at 50 MHz clock)
- DF_INC_RST, 393, reset deviation increment (75 kHz)
- GLIDE_STEP, 256, maximum acc_inc change per step
- GLIDE_DIV, 16, clk cycles per glide step (≥1)
- MUTE_CYC, 64, mute hold before glide (≥1)
- SETTLE_CYC, 64, hold after apply before unmute (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_valid  in  1  one-cycle request strobe, already in clk domain
- cfg_acc_inc  in  N  requested carrier increment
- cfg_df_inc  in  L  requested deviation increment
- cfg_dac_ena  in  D  requested DAC bit enables
- acc_inc  out  N  live carrier increment to modulator
- df_inc  out  L  live deviation increment
- dac_ena  out  D  live DAC enables
- mute  out  1  1 = modulator audio forced to zero
- busy  out  1  1 = sequence in progress or pending

Behaviour:
- Reset values:
  - acc_inc=ACC_INC_RST, df_inc=DF_INC_RST, dac_ena={D{1}}, mute=0, busy=0.
  - State=IDLE; pending flag cleared; all counters 0.
- All outputs are registered.
- States are IDLE, MUTE, GLIDE, SETTLE.
- IDLE:
  - When cfg_valid=1, capture the cfg_* fields into target registers, then go to MUTE.
  - mute=1 and busy=1 from the next cycle.
- MUTE:
  - Stays exactly MUTE_CYC cycles, then goes to GLIDE with div counter=0.
- GLIDE:
  - Each cycle: if acc_inc==target_acc, go to SETTLE next cycle.
  - Otherwise, when div==GLIDE_DIV-1, take one step and set div=0; otherwise div++.
  - Step rule: if |target_acc−acc_inc| ≤ GLIDE_STEP, acc_inc=target_acc; otherwise acc_inc ±= GLIDE_STEP toward the target.
  - Compare and subtract are unsigned on N+1 bits. acc_inc never overshoots and never wraps.
  - df_inc and dac_ena hold their old values throughout GLIDE.
- Equal target: if target_acc equals acc_inc on GLIDE entry, GLIDE lasts 1 cycle.
- GLIDE→SETTLE transition cycle: df_inc=target_df and dac_ena=target_ena are registered together.
- SETTLE:
  - Stays exactly SETTLE_CYC cycles.
  - At exit, if pending=0: go to IDLE with mute=0 and busy=0 on the next cycle.
  - At exit, if pending=1: load target from the pending registers, clear pending, and go to MUTE. mute and busy stay 1, with no unmute glitch.
- cfg_valid while not IDLE:
  - Overwrites the pending registers and sets pending=1.
  - Multiple requests collapse into the last one.
  - Does not disturb the current sequence.
- cfg_valid on the same cycle as SETTLE exit: the new cfg_* is used directly as the next target (it wins over older pending data), and pending ends at 0.
- rst asserted in any state, including mid-glide: on the next edge all registers return to reset values. Partial steps are discarded and pending is lost.
- busy=1 in MUTE, GLIDE and SETTLE; busy is 0 only in IDLE.

Test Plan:
1. Reset check: hold rst 2 cycles, then release -> acc_inc=52429, df_inc=393, dac_ena=4'hF, mute=0, busy=0; no change while cfg_valid=0 for 1000 cycles.
2. Up-retune: cfg_valid with acc=53429, df=500, ena=4'h3 -> mute=1 for 64 cycles, then acc_inc steps 52685, 52941, 53197, 53429 at 16-cycle intervals, with df/ena unchanged until the SETTLE entry edge; then df_inc=500, dac_ena=3, and mute/busy drop to 0 after 64 SETTLE cycles.
3. Down-retune with a sub-step remainder: 53429→53300 -> a single step of −129 after 16 GLIDE cycles; no overshoot.
4. Same-value retune: acc=current, df=600 -> GLIDE lasts 1 cycle; df_inc=600 at MUTE_CYC+2 cycles after the strobe.
5. Back-to-back: three requests during GLIDE (accs 60000, 61000, 62000) -> only 62000 is executed next; mute stays 1 continuously across the two sequences; busy is continuous.
6. Reset mid-glide: assert rst while acc_inc=52941 -> next cycle all outputs equal reset values, state=IDLE, and the queued request is discarded.
